build_info_regs: RTL

Parametrised build-identification block. It captures NUM_CH pairs of 64-bit git hash and 32-bit timestamp (scripts, top, and one per click module) into snapshot registers. It serves them to the block design over a single-cycle-latency register read handshake. It can also blink one channel's hash byte on a status LED as a framed pulse code, for board-level identification without software.

---
 rtl/build_info_regs.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/build_info_regs.sv
// Build-identification registers: snapshots per-channel git hash/timestamp, serves them over a
// one-cycle read port, and blinks a selected channel's hash byte on an LED as a framed pulse code.
module build_info_regs #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter logic [15:0] INFO_ID  = 16'hB1D0,
  localparam int unsigned AW = $clog2(3 * NUM_CH + 1),
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk100,
  input  logic                   rstn,
  input  logic [64*NUM_CH-1:0]   hash_i,
  input  logic [32*NUM_CH-1:0]   tstamp_i,
  input  logic                   snap_i,
  input  logic                   rd_req_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic                   rd_ack_o,
  output logic [31:0]            rd_data_o,
  output logic                   rd_err_o,
  input  logic                   blink_en_i,
  input  logic [CW-1:0]          blink_ch_i,
  output logic                   led_o,
  output logic                   frame_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSyncOn  = 3'd1;
  localparam logic [2:0] StSyncOff = 3'd2;
  localparam logic [2:0] StBitOn   = 3'd3;
  localparam logic [2:0] StBitOff  = 3'd4;
  localparam logic [2:0] StGap     = 3'd5;

  // ---------------------------------------------------------------------------------------------
  // Snapshot
  // ---------------------------------------------------------------------------------------------
  logic [63:0] hash_q   [NUM_CH];
  logic [31:0] tstamp_q [NUM_CH];
  logic        primed_q;
  logic        capture;

  // The first edge after reset release loads the snapshot without needing a snap pulse.
  assign capture = snap_i | ~primed_q;

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      primed_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        hash_q[c]   <= '0;
        tstamp_q[c] <= '0;
      end
    end else begin
      primed_q <= 1'b1;
      if (capture) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          hash_q[c]   <= hash_i[64*c +: 64];
          tstamp_q[c] <= tstamp_i[32*c +: 32];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic        rd_bad;
  logic        rd_ack_q;
  logic [31:0] rd_data_q;
  logic        rd_err_q;

  always_comb begin
    rd_word = 32'hDEAD_BEEF;
    rd_bad  = 1'b1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_addr_i == AW'(3 * c)) begin
        rd_word = hash_q[c][31:0];
        rd_bad  = 1'b0;
      end
      if (rd_addr_i == AW'(3 * c + 1)) begin
        rd_word = hash_q[c][63:32];
        rd_bad  = 1'b0;
      end
      if (rd_addr_i == AW'(3 * c + 2)) begin
        rd_word = tstamp_q[c];
        rd_bad  = 1'b0;
      end
    end
    if (rd_addr_i == AW'(3 * NUM_CH)) begin
      rd_word = {INFO_ID, 8'(NUM_CH), 8'h01};
      rd_bad  = 1'b0;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_ack_q <= rd_req_i;
      rd_err_q <= rd_req_i & rd_bad;
      if (rd_req_i) begin
        rd_data_q <= rd_word;
      end
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;
  assign rd_err_o  = rd_err_q;

  // ---------------------------------------------------------------------------------------------
  // Blink encoder
  // ---------------------------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    tcnt_q, tcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    sel_byte;
  logic [4:0]    dur;
  logic          tick;
  logic          last;

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    sel_byte = hash_q[0][7:0];
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (blink_ch_i == CW'(c)) begin
        sel_byte = hash_q[c][7:0];
      end
    end
  end

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (state_q == StIdle || !blink_en_i || tick) begin
      presc_d = '0;
    end
  end

  always_comb begin
    unique case (state_q)
      StSyncOn:  dur = 5'd8;
      StSyncOff: dur = 5'd4;
      StBitOn:   dur = byte_q[bit_q] ? 5'd3 : 5'd1;
      StBitOff:  dur = 5'd2;
      StGap:     dur = 5'd16;
      default:   dur = 5'd1;
    endcase
  end

  assign last = tick && (tcnt_q == dur - 5'd1);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    if (!blink_en_i) begin
      state_d = StIdle;
      tcnt_d  = '0;
      bit_d   = 3'd7;
    end else if (state_q == StIdle) begin
      state_d = StSyncOn;
      tcnt_d  = '0;
      byte_d  = sel_byte;
    end else if (last) begin
      tcnt_d = '0;
      unique case (state_q)
        StSyncOn:  state_d = StSyncOff;
        StSyncOff: begin
          state_d = StBitOn;
          bit_d   = 3'd7;
        end
        StBitOn:   state_d = StBitOff;
        StBitOff: begin
          if (bit_q == 3'd0) begin
            state_d = StGap;
          end else begin
            state_d = StBitOn;
            bit_d   = bit_q - 3'd1;
          end
        end
        StGap: begin
          state_d = StSyncOn;
          byte_d  = sel_byte;
        end
        default:   state_d = StIdle;
      endcase
    end else if (tick) begin
      tcnt_d = tcnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      presc_q <= '0;
      tcnt_q  <= '0;
      bit_q   <= 3'd7;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
    end
  end

  assign led_o   = (state_q == StSyncOn) || (state_q == StBitOn);
  assign frame_o = (state_q != StIdle) && (state_q != StGap);

endmodule
